// File: rtl/div_pkg.sv
// Shared constants and types for the EX-stage divider controller.
package div_pkg;

  localparam int DATA_W      = 32;
  localparam int CNT_W       = 5;
  localparam int DIV_LATENCY = DATA_W + 2;

  localparam logic [DATA_W-1:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  // Operation attributes captured at accept and applied in the final cycle
  typedef struct packed {
    logic qsign;
    logic rsign;
    logic dbz;
  } div_flags_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem_i, dvd_msb_i};
  assign diff    = shifted - {1'b0, dvs_i};
  assign q_o     = ~diff[W];
  assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer (radix-2 restoring) driving the EX-stage stall.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when |src1| < |src2|.
module div_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W = div_pkg::DATA_W,
  parameter int CNT_W  = div_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_valid,
  input  logic              div_req,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  input  logic              flush,
  output logic              div_stop,
  output logic              div_done,
  output logic [DATA_W-1:0] div_quot,
  output logic [DATA_W-1:0] div_rem
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // dq holds the dividend and fills with quotient bits from the bottom as it shifts
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] remo_q, remo_d;
  div_flags_t        flags_q, flags_d;

  logic              accept;
  logic              neg1, neg2;
  logic [DATA_W-1:0] abs1, abs2;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic [DATA_W-1:0] q_raw, quot_fin, rem_fin;
  logic              early;

  assign accept = es_valid && div_req && !flush;
  assign neg1   = div_signed && div_src1[DATA_W-1];
  assign neg2   = div_signed && div_src2[DATA_W-1];
  assign abs1   = neg1 ? -div_src1 : div_src1;
  assign abs2   = neg2 ? -div_src2 : div_src2;

`ifdef DIV_EARLY_OUT_EN
  assign early = (div_src2 != '0) && (abs1 < abs2);
`else
  assign early = 1'b0;
`endif

  div_step #(.W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dq_q[DATA_W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // With a zero divisor every trial subtract succeeds, so the remainder ends as
  // |src1| and the sign correction below turns it back into the raw src1.
  assign q_raw    = {dq_q[DATA_W-2:0], step_q};
  assign quot_fin = flags_q.dbz   ? DATA_W'(DIV_BY_ZERO_QUOT) :
                    flags_q.qsign ? -q_raw : q_raw;
  assign rem_fin  = flags_q.rsign ? -step_rem : step_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    flags_d = flags_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d         = CNT_W'(DATA_W - 1);
          dq_d          = abs1;
          rem_d         = '0;
          dvs_d         = abs2;
          flags_d.qsign = div_signed && (div_src1[DATA_W-1] ^ div_src2[DATA_W-1]);
          flags_d.rsign = neg1;
          flags_d.dbz   = (div_src2 == '0);
          state_d       = BUSY;
          if (early) begin
            quot_d  = '0;
            remo_d  = div_src1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dq_d  = q_raw;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            quot_d  = quot_fin;
            remo_d  = rem_fin;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      flags_q <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      flags_q <= flags_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign div_stop = resetn && es_valid && div_req && !flush && (state_q != DONE);
  assign div_done = (state_q == DONE);
  assign div_quot = quot_q;
  assign div_rem  = remo_q;

`ifndef SYNTHESIS
  a_busy_valid: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == BUSY) |-> (es_valid || flush))
    else $error("es_valid dropped while divider BUSY without flush");
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed DIV/DIVU vectors, monitor checks results,
// latency and stall length. Early-out expectations follow DIV_EARLY_OUT_EN.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        es_valid = 1'b0;
  logic        div_req = 1'b0;
  logic        div_signed = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        div_stop, div_done;
  logic [31:0] div_quot, div_rem;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  bit stim_done = 1'b0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
    int          lat;
    int          stops;
  } exp_t;
  exp_t sb[$];

  localparam int FULL = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
  localparam int EO_STOPS = 1;
`else
  localparam int EO_LAT = FULL;
  localparam int EO_STOPS = FULL;
`endif

  div_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .es_valid   (es_valid),
    .div_req    (div_req),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .flush      (flush),
    .div_stop   (div_stop),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk); #1;
    end
  endtask

  // Drive one request, queue its expectation, hold it until div_done is seen.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r,
                       input int lat, input int stops);
    exp_t e;
    int   n;
    es_valid   = 1'b1;
    div_req    = 1'b1;
    div_signed = sgn;
    div_src1   = a;
    div_src2   = b;
    e.q = q; e.r = r; e.cyc = cyc; e.lat = lat; e.stops = stops;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (n > 60) begin
        $display("FAIL done_timeout: no div_done after %0d cycles, want %0d", n, lat);
        $fatal(1, "bench stopped");
      end
    end while (!div_done);
    es_valid = 1'b0;
    div_req  = 1'b0;
  endtask

  initial begin : stim
    // request asserted during reset must not stall
    es_valid = 1'b1; div_req = 1'b1; div_src1 = 32'd100; div_src2 = 32'd7;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    es_valid = 1'b0; div_req = 1'b0;
    idle(1);
    resetn = 1'b1;
    idle(1);

    issue(1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        FULL, FULL); idle(1);
    issue(1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, FULL, FULL); idle(1);
    issue(1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, FULL, FULL); idle(1);
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, FULL, FULL); idle(1);
    issue(1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, FULL, FULL); idle(1);
    issue(1'b1, 32'h80000005, 32'h00000000, 32'hFFFFFFFF, 32'h80000005, FULL, FULL); idle(1);
    issue(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, FULL, FULL); idle(1);
    issue(1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, FULL, FULL); idle(1);
    issue(1'b0, 32'd5,        32'd5,        32'd1,        32'd0,        FULL, FULL); idle(1);

    // flush in BUSY cycle 10, then a fresh DIVU 9/3
    es_valid = 1'b1; div_req = 1'b1; div_signed = 1'b0;
    div_src1 = 32'd100; div_src2 = 32'd7;
    idle(9);
    flush = 1'b1;
    idle(1);
    flush = 1'b0; es_valid = 1'b0; div_req = 1'b0;
    idle(3);
    issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, FULL, FULL); idle(1);

    // small-dividend case, then a request presented in the DONE cycle
    issue(1'b0, 32'd3,   32'd10, 32'd0,  32'd3, EO_LAT, EO_STOPS);
    issue(1'b0, 32'd100, 32'd7,  32'd14, 32'd2, FULL + 1, FULL); idle(1);
    issue(1'b1, 32'hFFFFFFFD, 32'h0000000A, 32'h00000000, 32'hFFFFFFFD, EO_LAT, EO_STOPS);
    idle(1);

    // asynchronous reset in the middle of an operation
    es_valid = 1'b1; div_req = 1'b1; div_signed = 1'b0;
    div_src1 = 32'd1000; div_src2 = 32'd3;
    idle(5);
    #2;
    resetn = 1'b0; es_valid = 1'b0; div_req = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(1);
    issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, FULL, FULL);
    idle(3);
    stim_done = 1'b1;
  end

  initial begin : mon
    exp_t        e;
    int          stop_cnt;
    bit          prev_done;
    logic [31:0] last_q, last_r;
    stop_cnt = 0; prev_done = 1'b0; last_q = '0; last_r = '0;
    while (!stim_done) begin
      @(negedge clk); #2;
      if (!resetn) begin
        chk("reset_stop", div_stop, 0);
        chk("reset_done", div_done, 0);
        chk("reset_quot", div_quot, 0);
        chk("reset_rem",  div_rem,  0);
        stop_cnt = 0; prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          chk("hold_quot", div_quot, last_q);
          chk("hold_rem",  div_rem,  last_r);
        end
        prev_done = 1'b0;
        if (div_done) begin
          chk("done_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("quot",    div_quot,    e.q);
            chk("rem",     div_rem,     e.r);
            chk("latency", cyc - e.cyc, e.lat);
            chk("stall",   stop_cnt,    e.stops);
          end
          last_q = div_quot; last_r = div_rem; prev_done = 1'b1;
          stop_cnt = 0;
        end
        if (flush) begin
          chk("flush_stop", div_stop, 0);
          stop_cnt = 0;
        end
        if (div_stop) stop_cnt++;
      end
    end
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want end");
    $fatal(1, "bench stopped");
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle controller that sequences the EX-stage integer divider for DIV/DIVU.
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.
- Drives `div_stop`, the only EX-stage stall source seen by the hazard unit, and returns the quotient and remainder to EX for the HI/LO write.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == DATA_W.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- es_valid  in  1  EX stage holds a valid instruction.
- div_req  in  1  EX instruction is DIV/DIVU; held stable while div_stop=1.
- div_signed  in  1  1=DIV, 0=DIVU; sampled at accept.
- div_src1  in  DATA_W  dividend; sampled at accept.
- div_src2  in  DATA_W  divisor; sampled at accept.
- flush  in  1  exception/ERET flush of EX; aborts the operation.
- div_stop  out  1  stall request to the hazard unit (stallE=01).
- div_done  out  1  one-cycle pulse; results valid.
- div_quot  out  DATA_W  quotient (to LO).
- div_rem  out  DATA_W  remainder (to HI).

Behaviour:
- Reset: state=IDLE, counter=0, div_done=0, div_quot=0, div_rem=0. div_stop=0 while reset is asserted.
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY when es_valid && div_req && !flush (accept). On accept, register:
  - |src1| and |src2| (absolute values only if div_signed),
  - quotient sign = signed && (src1[31]^src2[31]),
  - remainder sign = signed && src1[31],
  - divide-by-zero flag (src2==0).
  - Counter is set to DATA_W-1.
- BUSY, each cycle:
  - shifted = {rem[31:0], dvd_msb}, 33 bits;
  - diff = shifted - {1'b0, divisor};
  - if diff[32]==0: rem = diff[31:0] and shift 1 into the quotient; else rem = shifted[31:0] and shift in 0.
  - Counter decrements; on counter==0 the state moves to DONE.
- DONE: drive div_done=1 and the sign-corrected results:
  - quotient is negated if the quotient sign is set;
  - remainder is negated if the remainder sign is set;
  - all arithmetic wraps modulo 2**32.
  - div_quot/div_rem keep their value after DONE until the next DONE.
  - Next state is unconditionally IDLE; EX advances in the DONE cycle by contract.
- Divide by zero: full latency still applies; result forced to quot=32'hFFFFFFFF, rem=src1 (raw, not sign-corrected).
- div_stop (combinational) = es_valid && div_req && !flush && state!=DONE. It is high in the accept cycle and in every BUSY cycle.
- Latency: accept cycle + 32 BUSY cycles. div_stop is high for 33 cycles; div_done rises in cycle 34 relative to accept at cycle 1.
- Flush in any state: div_stop=0 in that cycle, next state is IDLE, no div_done. A flush in the DONE cycle still leaves div_done high, and EX discards it.
- Asynchronous reset mid-operation: immediate return to IDLE; partial results are discarded.
- es_valid dropping in BUSY without flush is illegal; it is asserted against in simulation.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: at accept, if |src1| < |src2| and src2!=0, the next state is DONE directly with quot=0 and rem=src1 (raw). div_stop is high for 1 cycle and div_done arrives in cycle 2.
- When undefined: every operation takes the full 34-cycle latency; no comparator is synthesised.

Decomposition:
- Package div_pkg contains:
  - DATA_W, CNT_W;
  - the state enum {IDLE, BUSY, DONE};
  - DIV_LATENCY=DATA_W+2;
  - DIV_BY_ZERO_QUOT=32'hFFFFFFFF.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, dividend msb, divisor.
  - Outputs: next rem, quotient bit.
  - Reusable if a radix-4 variant is built later.

Test Plan:
- Unsigned: DIVU 100/7, accept at cycle 1 → div_stop high cycles 1–33; div_done in cycle 34 with quot=14, rem=2.
- Signed: DIV -7/2 (FFFFFFF9/00000002) → quot=FFFFFFFD, rem=FFFFFFFF. Also DIV 7/-2 → quot=FFFFFFFD, rem=00000001.
- Overflow wrap: DIV 80000000/FFFFFFFF → quot=80000000, rem=00000000, no hang.
- Zero divisor: DIVU 12345678/0 → quot=FFFFFFFF, rem=12345678, still 34 cycles.
- Flush: flush in BUSY cycle 10 → div_stop=0 that cycle, IDLE next cycle, no div_done. A new DIVU 9/3 is then accepted and returns quot=3, rem=0 after the full latency.
- With DIV_EARLY_OUT_EN: DIVU 3/10 → div_stop high for 1 cycle, div_done in cycle 2 with quot=0, rem=3. Back-to-back DIVU 100/7 is accepted in cycle 3.
